mii_frame_scheduler: RTL and testbench
======================================

# mii_frame_scheduler

Round-robin scheduler that shares the single MAC frame generator / MII encoder (`mac_mii_top`) between several frame sources. It grants one requester at a time and pulses the generator's start input. It then tracks the frame on the 64-bit MII output by watching for the start (0xFB) and terminate (0xFD) control characters, and enforces an inter-frame gap before the next grant. It sits directly in front of `mac_mii_top`, and a frame source's payload/header muxing is driven from `o_sel`.

## Interface
- `N_REQ`, 4: number of requesters (2..16).
- `START_CYCLES`, 2: length of the `o_start` pulse in clocks (≥1).
- `IFG_CYCLES`, 3: idle clocks between EOF detection and the next grant (0 allowed).
- `TIMEOUT_CYCLES`, 256: maximum clocks in WAIT_SOF plus WAIT_EOF before abort (≥2).

- `clk` in 1: single clock, rising edge.
- `i_rst_n` in 1: asynchronous, active-low reset.
- `i_req` in N_REQ: level request per source; sampled only in IDLE.
- `i_mii_data` in 64: generator MII data, byte lane i = bits [8i+7:8i].
- `i_mii_ctrl` in 8: generator MII control, bit i flags lane i as a control character.
- `o_start` out 1: start pulse to the generator.
- `o_grant` out N_REQ: one-hot grant, held from START through WAIT_EOF.
- `o_sel` out $clog2(N_REQ): index of the granted source; holds its last value when idle.
- `o_done` out N_REQ: one-clock pulse on the granted bit when its frame completes.
- `o_timeout` out 1: one-clock pulse when a frame is aborted.
- `o_busy` out 1: high whenever state ≠ IDLE.
- `o_frame_count` out 16: count of completed frames; wraps 0xFFFF→0x0000.

## Operation
- SOF: `i_mii_ctrl[0]`=1 and lane 0 byte = 0xFB.
- EOF: any lane i with `i_mii_ctrl[i]`=1 and byte = 0xFD.
- FSM states:
  - IDLE: if `i_req`≠0, pick the winner by round-robin starting at `rr_ptr`, then → START.
  - START: `o_start`=1 for START_CYCLES clocks, then → WAIT_SOF.
  - WAIT_SOF: SOF → WAIT_EOF. SOF and EOF in the same word → complete.
  - WAIT_EOF: EOF → complete.
  - Complete: pulse `o_done[sel]`, increment `o_frame_count`, → GAP (or → IDLE if IFG_CYCLES=0).
  - GAP: count IFG_CYCLES clocks, then → IDLE.
- Round-robin: after a grant to k, `rr_ptr` = (k+1) mod N_REQ. `rr_ptr` resets to 0.
- EOF seen in START or WAIT_SOF without a SOF is ignored. SOF seen in WAIT_EOF is ignored.
- Timeout counter:
  - Cleared on entering WAIT_SOF; counts in WAIT_SOF and WAIT_EOF.
  - On reaching TIMEOUT_CYCLES-1 without completion: pulse `o_timeout`, no `o_done`, no count increment, → GAP.
  - `rr_ptr` still advances.
- Deassertion of `i_req[k]` while granted is ignored; the frame runs to completion or timeout.
- Reset, at any time including mid-frame:
  - State → IDLE; all outputs 0 (`o_start`, `o_grant`, `o_sel`, `o_done`, `o_timeout`, `o_busy`, `o_frame_count`).
  - `rr_ptr` → 0 and counters cleared.
  - No `o_done` or `o_timeout` is issued for the aborted frame.

## Timing
- All outputs are registered.
- Request visible in IDLE at edge t: from edge t+1, `o_grant`, `o_sel`, `o_busy` and `o_start` are high. `o_start` stays high through edge t+START_CYCLES.
- SOF/EOF are sampled from the inputs at the clock edge. The state change is effective the next clock.
- EOF sampled at edge e: `o_done` is high for the single clock after e, and `o_grant` falls at the same edge.
- `o_frame_count` updates with `o_done`.
- GAP is exactly IFG_CYCLES clocks with `o_grant`=0 and `o_busy`=1. The earliest next `o_grant` is at edge e+IFG_CYCLES+2.
- The timeout pulse aligns like `o_done`: one clock, with `o_grant` dropping at the same edge.
- Simultaneous requests are resolved in the single IDLE cycle; exactly one grant is issued.

## Test plan
- Single source: `i_req`=4'b0001, generator sends an 8-byte payload frame → `o_start` high 2 clocks, `o_grant`=0001 until EOF, `o_done`=0001 for 1 clock, `o_frame_count`=1, next grant no earlier than IFG_CYCLES+1 clocks later.
- All four requesting continuously (`i_req`=4'b1111) → grant order 0,1,2,3,0 and `o_frame_count`=5 after five EOFs.
- Requester drops: `i_req`=0010 granted, then `i_req`←0 after 1 clock → frame completes, `o_done`=0010, return to IDLE.
- Timeout: inject no SOF with TIMEOUT_CYCLES=16 → `o_timeout` pulses 16 clocks after entering WAIT_SOF, `o_done` stays 0, count unchanged, round-robin advances.
- Reset mid-frame: assert `i_rst_n`=0 in WAIT_EOF → all outputs 0 asynchronously. After release with `i_req`=1000, the grant goes to source 3 (`rr_ptr`=0 search) and the first frame completes normally.
- Spurious control: EOF byte 0xFD in lane 5 before SOF → ignored. SOF then EOF in lane 3 → single `o_done`; `o_frame_count` wrap from 0xFFFF → 0x0000 is checked via forced preload.

Source files
------------

// File: rtl/mii_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : mii_frame_scheduler
// Description : Round-robin scheduler in front of a shared MAC frame
//               generator / MII encoder. It grants one frame source at a
//               time, pulses the generator start input, follows the frame on
//               the 64-bit MII stream (0xFB start, 0xFD terminate), enforces
//               an inter-frame gap and aborts frames that never complete.
// Ports       :
//   clk            - clock, rising edge
//   i_rst_n        - asynchronous active-low reset
//   i_req          - level request per source (sampled only while idle)
//   i_mii_data     - generator MII data, lane i = bits [8i+7:8i]
//   i_mii_ctrl     - generator MII control flags, bit i = lane i
//   o_start        - start pulse to the generator (START_CYCLES clocks)
//   o_grant        - one-hot grant, held from start until the frame ends
//   o_sel          - index of the granted source (holds when idle)
//   o_done         - one-clock pulse on the granted bit at frame completion
//   o_timeout      - one-clock pulse when a frame is aborted
//   o_busy         - high whenever the scheduler is not idle
//   o_frame_count  - completed frame counter, wraps at 16 bits
// Revision    : 1.0 - initial release
// ============================================================================
module mii_frame_scheduler #(
    parameter int N_REQ          = 4,
    parameter int START_CYCLES   = 2,
    parameter int IFG_CYCLES     = 3,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                       clk,
    input  logic                       i_rst_n,
    input  logic [N_REQ-1:0]           i_req,
    input  logic [63:0]                i_mii_data,
    input  logic [7:0]                 i_mii_ctrl,
    output logic                       o_start,
    output logic [N_REQ-1:0]           o_grant,
    output logic [$clog2(N_REQ)-1:0]   o_sel,
    output logic [N_REQ-1:0]           o_done,
    output logic                       o_timeout,
    output logic                       o_busy,
    output logic [15:0]                o_frame_count
);

    localparam int c_sel_w = $clog2(N_REQ);
    localparam int c_st_w  = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
    localparam int c_to_w  = $clog2(TIMEOUT_CYCLES);
    localparam int c_gap_w = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;

    // S_FINISH is the single clock that carries the o_done / o_timeout pulse;
    // it keeps o_busy high and o_grant low, and is followed by the gap.
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_START    = 3'd1,
        S_WAIT_SOF = 3'd2,
        S_WAIT_EOF = 3'd3,
        S_FINISH   = 3'd4,
        S_GAP      = 3'd5
    } state_t;

    state_t               state_q,       state_d;
    logic [c_sel_w-1:0]   sel_q,         sel_d;
    logic [c_sel_w-1:0]   rr_ptr_q,      rr_ptr_d;
    logic [c_st_w-1:0]    start_cnt_q,   start_cnt_d;
    logic [c_to_w-1:0]    to_cnt_q,      to_cnt_d;
    logic [c_gap_w-1:0]   gap_cnt_q,     gap_cnt_d;
    logic [15:0]          frame_count_q, frame_count_d;
    logic [N_REQ-1:0]     grant_q,       grant_d;
    logic [N_REQ-1:0]     done_q,        done_d;
    logic                 timeout_q,     timeout_d;
    logic                 start_q,       start_d;
    logic                 busy_q,        busy_d;

    logic [7:0]           w_eof_lane;
    logic                 w_sof;
    logic                 w_eof;
    logic                 w_to_expired;
    logic                 w_complete;
    logic                 w_abort;
    logic                 w_found;
    logic [c_sel_w-1:0]   w_winner;
    logic [c_sel_w-1:0]   w_idx;
    int                   w_idx_int;

    // ------------------------------------------------------------------
    // MII control-character detection
    // ------------------------------------------------------------------
    assign w_sof = i_mii_ctrl[0] && (i_mii_data[7:0] == 8'hFB);

    for (genvar g = 0; g < 8; g++) begin : g_lane
        assign w_eof_lane[g] = i_mii_ctrl[g] && (i_mii_data[8*g +: 8] == 8'hFD);
    end

    assign w_eof        = |w_eof_lane;
    assign w_to_expired = (int'(to_cnt_q) >= TIMEOUT_CYCLES - 1);

    // ------------------------------------------------------------------
    // Round-robin search: first active request at or after rr_ptr_q
    // ------------------------------------------------------------------
    always_comb begin : p_arbiter
        w_found   = 1'b0;
        w_winner  = '0;
        w_idx_int = 0;
        w_idx     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_idx_int = int'(rr_ptr_q) + i;
            if (w_idx_int >= N_REQ) begin
                w_idx_int = w_idx_int - N_REQ;
            end
            w_idx = c_sel_w'(w_idx_int);
            if (!w_found && i_req[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin : p_next
        state_d       = state_q;
        sel_d         = sel_q;
        rr_ptr_d      = rr_ptr_q;
        start_cnt_d   = start_cnt_q;
        to_cnt_d      = to_cnt_q;
        gap_cnt_d     = gap_cnt_q;
        frame_count_d = frame_count_q;
        done_d        = '0;
        timeout_d     = 1'b0;
        w_complete    = 1'b0;
        w_abort       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (w_found) begin
                    sel_d       = w_winner;
                    // Pointer advances at grant time, so an aborted frame
                    // still moves the round-robin on.
                    rr_ptr_d    = (int'(w_winner) == N_REQ - 1) ? '0 : w_winner + 1'b1;
                    start_cnt_d = '0;
                    state_d     = S_START;
                end
            end
            S_START: begin
                // Control characters during START are not tracked.
                if (int'(start_cnt_q) >= START_CYCLES - 1) begin
                    to_cnt_d = '0;
                    state_d  = S_WAIT_SOF;
                end else begin
                    start_cnt_d = start_cnt_q + 1'b1;
                end
            end
            S_WAIT_SOF: begin
                // A lone EOF here belongs to no frame and is ignored.
                if (w_sof && w_eof) begin
                    w_complete = 1'b1;
                end else if (w_to_expired) begin
                    w_abort = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                    if (w_sof) begin
                        state_d = S_WAIT_EOF;
                    end
                end
            end
            S_WAIT_EOF: begin
                if (w_eof) begin
                    w_complete = 1'b1;
                end else if (w_to_expired) begin
                    w_abort = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            S_FINISH: begin
                gap_cnt_d = '0;
                state_d   = (IFG_CYCLES == 0) ? S_IDLE : S_GAP;
            end
            S_GAP: begin
                if (int'(gap_cnt_q) >= IFG_CYCLES - 1) begin
                    state_d = S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (w_complete) begin
            done_d[sel_q] = 1'b1;
            frame_count_d = frame_count_q + 16'd1;
            state_d       = S_FINISH;
        end
        if (w_abort) begin
            timeout_d = 1'b1;
            state_d   = S_FINISH;
        end
    end

    // ------------------------------------------------------------------
    // Output decode from the next state; every output leaves a flop
    // ------------------------------------------------------------------
    always_comb begin : p_out
        grant_d = '0;
        if ((state_d == S_START) || (state_d == S_WAIT_SOF) || (state_d == S_WAIT_EOF)) begin
            grant_d[sel_d] = 1'b1;
        end
        start_d = (state_d == S_START);
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge i_rst_n) begin : p_regs
        if (!i_rst_n) begin
            state_q       <= S_IDLE;
            sel_q         <= '0;
            rr_ptr_q      <= '0;
            start_cnt_q   <= '0;
            to_cnt_q      <= '0;
            gap_cnt_q     <= '0;
            frame_count_q <= '0;
            grant_q       <= '0;
            done_q        <= '0;
            timeout_q     <= 1'b0;
            start_q       <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            sel_q         <= sel_d;
            rr_ptr_q      <= rr_ptr_d;
            start_cnt_q   <= start_cnt_d;
            to_cnt_q      <= to_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
            frame_count_q <= frame_count_d;
            grant_q       <= grant_d;
            done_q        <= done_d;
            timeout_q     <= timeout_d;
            start_q       <= start_d;
            busy_q        <= busy_d;
        end
    end

    assign o_start       = start_q;
    assign o_grant       = grant_q;
    assign o_sel         = sel_q;
    assign o_done        = done_q;
    assign o_timeout     = timeout_q;
    assign o_busy        = busy_q;
    assign o_frame_count = frame_count_q;

endmodule
`default_nettype wire

// File: tb/tb_mii_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_mii_frame_scheduler
// Description : Self-checking bench for mii_frame_scheduler. The bench plays
//               the generator side of the MII stream and keeps a reference
//               model of the arbitration order and frame count.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mii_frame_scheduler;

    localparam int N   = 4;
    localparam int SC  = 2;
    localparam int IFG = 3;
    localparam int TO  = 16;

    logic        clk = 1'b0;
    logic        i_rst_n = 1'b1;
    logic [3:0]  i_req = '0;
    logic [63:0] i_mii_data = '0;
    logic [7:0]  i_mii_ctrl = '0;
    logic        o_start;
    logic [3:0]  o_grant;
    logic [1:0]  o_sel;
    logic [3:0]  o_done;
    logic        o_timeout;
    logic        o_busy;
    logic [15:0] o_frame_count;

    int          vec = 0;
    int          err = 0;
    int          m_rr = 0;
    logic [15:0] m_count = '0;

    mii_frame_scheduler #(
        .N_REQ         (N),
        .START_CYCLES  (SC),
        .IFG_CYCLES    (IFG),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk          (clk),
        .i_rst_n      (i_rst_n),
        .i_req        (i_req),
        .i_mii_data   (i_mii_data),
        .i_mii_ctrl   (i_mii_ctrl),
        .o_start      (o_start),
        .o_grant      (o_grant),
        .o_sel        (o_sel),
        .o_done       (o_done),
        .o_timeout    (o_timeout),
        .o_busy       (o_busy),
        .o_frame_count(o_frame_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic int rr_pick(input logic [3:0] r, input int p);
        for (int i = 0; i < N; i++) begin
            if (r[(p + i) % N]) return (p + i) % N;
        end
        return -1;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put_idle();
        i_mii_data = {8{8'h07}};
        i_mii_ctrl = 8'hFF;
    endtask

    task automatic put_data();
        i_mii_data = {$urandom, $urandom};
        i_mii_ctrl = 8'h00;
    endtask

    task automatic put_sof();
        logic [63:0] d;
        d = {$urandom, $urandom};
        d[7:0] = 8'hFB;
        i_mii_data = d;
        i_mii_ctrl = 8'h01;
    endtask

    task automatic put_eof(input int lane, input bit with_sof);
        logic [63:0] d;
        logic [7:0]  c;
        d = {$urandom, $urandom};
        c = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (i == lane) begin
                d[8*i +: 8] = 8'hFD;
                c[i] = 1'b1;
            end else if (i > lane) begin
                d[8*i +: 8] = 8'h07;
                c[i] = 1'b1;
            end
        end
        if (with_sof) begin
            d[7:0] = 8'hFB;
            c[0]   = 1'b1;
        end
        i_mii_data = d;
        i_mii_ctrl = c;
    endtask

    task automatic do_reset();
        i_req = '0;
        put_idle();
        i_rst_n = 1'b0;
        @(posedge clk);
        #3;
        i_rst_n = 1'b1;
        m_rr    = 0;
        m_count = '0;
    endtask

    // One full transaction. lat = ticks from applying the request until the
    // grant shows up; with hold=0 it also walks the gap back to idle.
    task automatic do_frame(input logic [3:0] req, input int npay, input int eof_lane,
                            input bit same_word, input bit spurious, input bit drop,
                            input bit hold, output int lat);
        int         k;
        logic [3:0] g;
        k = rr_pick(req, m_rr);
        g = 4'b0001 << k;
        i_req = req;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (o_grant === 4'b0000 && lat < 40);
        vec++;
        if (o_grant !== g || o_sel !== 2'(k) || o_start !== 1'b1 || o_busy !== 1'b1) begin
            err++;
            $display("FAIL grant: grant=%b sel=%0d start=%b busy=%b, required grant=%b sel=%0d start=1 busy=1",
                     o_grant, o_sel, o_start, o_busy, g, k);
        end
        m_rr = (k + 1) % N;
        if (drop) i_req = '0;
        if (spurious) put_eof(5, 1'b0); else put_idle();
        tick();
        vec++;
        if (o_start !== 1'b1 || o_grant !== g || o_done !== 4'b0) begin
            err++;
            $display("FAIL start_hold: start=%b grant=%b done=%b, required start=1 grant=%b done=0000",
                     o_start, o_grant, o_done, g);
        end
        tick();
        vec++;
        if (o_start !== 1'b0 || o_grant !== g || o_done !== 4'b0) begin
            err++;
            $display("FAIL start_end: start=%b grant=%b done=%b, required start=0 grant=%b done=0000",
                     o_start, o_grant, o_done, g);
        end
        if (spurious) begin
            tick();
            vec++;
            if (o_grant !== g || o_done !== 4'b0) begin
                err++;
                $display("FAIL spurious_eof: grant=%b done=%b, required grant=%b done=0000", o_grant, o_done, g);
            end
        end
        if (same_word) begin
            put_eof(eof_lane, 1'b1);
        end else begin
            put_sof();
            tick();
            vec++;
            if (o_grant !== g || o_done !== 4'b0) begin
                err++;
                $display("FAIL sof: grant=%b done=%b, required grant=%b done=0000", o_grant, o_done, g);
            end
            for (int i = 0; i < npay; i++) begin
                put_data();
                tick();
                vec++;
                if (o_grant !== g || o_done !== 4'b0) begin
                    err++;
                    $display("FAIL payload: grant=%b done=%b, required grant=%b done=0000", o_grant, o_done, g);
                end
            end
            put_eof(eof_lane, 1'b0);
        end
        tick();
        m_count = m_count + 16'd1;
        vec++;
        if (o_done !== g || o_grant !== 4'b0 || o_busy !== 1'b1 || o_timeout !== 1'b0 ||
            o_frame_count !== m_count) begin
            err++;
            $display("FAIL done: done=%b grant=%b busy=%b timeout=%b count=%h, required done=%b grant=0000 busy=1 timeout=0 count=%h",
                     o_done, o_grant, o_busy, o_timeout, o_frame_count, g, m_count);
        end
        put_idle();
        if (!hold) i_req = '0;
        tick();
        vec++;
        if (o_done !== 4'b0 || o_grant !== 4'b0 || o_busy !== 1'b1 || o_frame_count !== m_count) begin
            err++;
            $display("FAIL done_pulse: done=%b grant=%b busy=%b count=%h, required done=0000 grant=0000 busy=1 count=%h",
                     o_done, o_grant, o_busy, o_frame_count, m_count);
        end
        if (!hold) begin
            // Busy stays high through the gap, then idle exactly IFG+1 clocks after EOF.
            for (int n = 1; n <= IFG; n++) begin
                tick();
                vec++;
                if (o_busy !== (n < IFG) || o_grant !== 4'b0) begin
                    err++;
                    $display("FAIL gap: step %0d busy=%b grant=%b, required busy=%b grant=0000",
                             n, o_busy, o_grant, (n < IFG));
                end
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        put_idle();
        #3;
        i_rst_n = 1'b0;
        #1;
        vec++;
        if ({o_start, o_grant, o_sel, o_done, o_timeout, o_busy, o_frame_count} !== '0) begin
            err++;
            $display("FAIL reset_outputs: start=%b grant=%b sel=%0d done=%b timeout=%b busy=%b count=%h, required all 0",
                     o_start, o_grant, o_sel, o_done, o_timeout, o_busy, o_frame_count);
        end
        @(posedge clk);
        #3;
        i_rst_n = 1'b1;
        tick();
        vec++;
        if (o_busy !== 1'b0 || o_grant !== 4'b0 || o_frame_count !== 16'h0) begin
            err++;
            $display("FAIL reset_idle: busy=%b grant=%b count=%h, required busy=0 grant=0000 count=0000",
                     o_busy, o_grant, o_frame_count);
        end
    endtask

    task automatic test_single();
        int lat;
        do_frame(4'b0001, 1, $urandom_range(0, 7), 1'b0, 1'b0, 1'b0, 1'b1, lat);
        vec++;
        if (lat !== 1) begin
            err++;
            $display("FAIL single_latency: got %0d ticks, required 1", lat);
        end
        // The previous call already consumed the clock after EOF, so the
        // grant at EOF+IFG+2 shows up IFG+1 ticks into this call.
        do_frame(4'b0001, 1, $urandom_range(0, 7), 1'b0, 1'b0, 1'b0, 1'b0, lat);
        vec++;
        if (lat !== IFG + 1) begin
            err++;
            $display("FAIL regrant_gap: got %0d ticks, required %0d", lat, IFG + 1);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        int exp_order [5] = '{0, 1, 2, 3, 0};
        do_reset();
        for (int f = 0; f < 5; f++) begin
            vec++;
            if (rr_pick(4'b1111, m_rr) !== exp_order[f]) begin
                err++;
                $display("FAIL rr_order: frame %0d model pick %0d, required %0d", f, rr_pick(4'b1111, m_rr), exp_order[f]);
            end
            do_frame(4'b1111, $urandom_range(0, 4), $urandom_range(0, 7), 1'b0, 1'b0, 1'b0, (f < 4), lat);
            vec++;
            if (lat !== ((f == 0) ? 1 : IFG + 1)) begin
                err++;
                $display("FAIL b2b_latency: frame %0d got %0d ticks, required %0d", f, lat, (f == 0) ? 1 : IFG + 1);
            end
        end
        vec++;
        if (o_frame_count !== 16'd5) begin
            err++;
            $display("FAIL b2b_count: got %0d, required 5", o_frame_count);
        end
    endtask

    task automatic test_drop();
        int lat;
        do_frame(4'b0010, 2, $urandom_range(0, 7), 1'b0, 1'b0, 1'b1, 1'b0, lat);
        vec++;
        if (o_busy !== 1'b0 || o_sel !== 2'd1) begin
            err++;
            $display("FAIL drop_idle: busy=%b sel=%0d, required busy=0 sel=1", o_busy, o_sel);
        end
    endtask

    task automatic test_random_arb();
        int lat;
        bit sw;
        for (int f = 0; f < 8; f++) begin
            sw = 1'($urandom_range(0, 1));
            do_frame(4'($urandom_range(1, 15)), $urandom_range(0, 4),
                     sw ? $urandom_range(1, 7) : $urandom_range(0, 7),
                     sw, 1'($urandom_range(0, 1)), 1'b0, 1'b0, lat);
            vec++;
            if (lat !== 1) begin
                err++;
                $display("FAIL rand_latency: frame %0d got %0d ticks, required 1", f, lat);
            end
        end
    endtask

    task automatic test_timeout();
        int         k;
        int         lat;
        logic [3:0] g;
        logic [3:0] req;
        req = 4'b0100;
        k = rr_pick(req, m_rr);
        g = 4'b0001 << k;
        i_req = req;
        put_idle();
        tick();
        m_rr = (k + 1) % N;
        i_req = '0;
        // WAIT_SOF starts SC ticks after the grant; abort lands TO ticks later.
        for (int n = 1; n <= SC + TO; n++) begin
            tick();
            if (n < SC + TO) begin
                if (o_timeout !== 1'b0 || o_grant !== g || o_done !== 4'b0) begin
                    vec++;
                    err++;
                    $display("FAIL timeout_early: step %0d timeout=%b grant=%b done=%b, required 0/%b/0000",
                             n, o_timeout, o_grant, o_done, g);
                end
            end else begin
                vec++;
                if (o_timeout !== 1'b1 || o_done !== 4'b0 || o_grant !== 4'b0 || o_busy !== 1'b1 ||
                    o_frame_count !== m_count) begin
                    err++;
                    $display("FAIL timeout_pulse: timeout=%b done=%b grant=%b busy=%b count=%h, required 1/0000/0000/1/%h",
                             o_timeout, o_done, o_grant, o_busy, o_frame_count, m_count);
                end
            end
        end
        tick();
        vec++;
        if (o_timeout !== 1'b0) begin
            err++;
            $display("FAIL timeout_single: got %b, required 0", o_timeout);
        end
        for (int n = 1; n <= IFG; n++) tick();
        vec++;
        if (o_busy !== 1'b0) begin
            err++;
            $display("FAIL timeout_idle: busy=%b, required 0", o_busy);
        end
        // Round-robin moved past the aborted source.
        do_frame(4'b1111, 1, $urandom_range(0, 7), 1'b0, 1'b0, 1'b0, 1'b0, lat);
    endtask

    task automatic test_reset_midframe();
        int lat;
        i_req = 4'b0010;
        put_idle();
        tick();
        tick();
        tick();
        put_sof();
        tick();
        put_data();
        i_req = '0;
        #2;
        i_rst_n = 1'b0;
        #1;
        vec++;
        if ({o_start, o_grant, o_sel, o_done, o_timeout, o_busy, o_frame_count} !== '0) begin
            err++;
            $display("FAIL midframe_reset: start=%b grant=%b sel=%0d done=%b timeout=%b busy=%b count=%h, required all 0",
                     o_start, o_grant, o_sel, o_done, o_timeout, o_busy, o_frame_count);
        end
        put_eof(2, 1'b0);
        @(posedge clk);
        #3;
        i_rst_n = 1'b1;
        m_rr    = 0;
        m_count = '0;
        put_idle();
        tick();
        vec++;
        if (o_done !== 4'b0 || o_timeout !== 1'b0 || o_busy !== 1'b0) begin
            err++;
            $display("FAIL midframe_quiet: done=%b timeout=%b busy=%b, required 0000/0/0", o_done, o_timeout, o_busy);
        end
        do_frame(4'b1000, 2, $urandom_range(0, 7), 1'b0, 1'b0, 1'b0, 1'b0, lat);
        vec++;
        if (o_sel !== 2'd3 || o_frame_count !== 16'd1) begin
            err++;
            $display("FAIL midframe_recover: sel=%0d count=%0d, required sel=3 count=1", o_sel, o_frame_count);
        end
    endtask

    task automatic test_spurious_wrap();
        int lat;
        force dut.frame_count_q = 16'hFFFF;
        #1;
        release dut.frame_count_q;
        m_count = 16'hFFFF;
        vec++;
        if (o_frame_count !== 16'hFFFF) begin
            err++;
            $display("FAIL preload: got %h, required FFFF", o_frame_count);
        end
        do_frame(4'($urandom_range(1, 15)), 2, 3, 1'b0, 1'b1, 1'b0, 1'b0, lat);
        vec++;
        if (o_frame_count !== 16'h0000) begin
            err++;
            $display("FAIL count_wrap: got %h, required 0000", o_frame_count);
        end
        do_frame(4'($urandom_range(1, 15)), 0, 3, 1'b1, 1'b1, 1'b0, 1'b0, lat);
    endtask

    initial begin
        put_idle();
        test_reset();
        test_single();
        test_back_to_back();
        test_drop();
        test_random_arb();
        test_timeout();
        test_reset_midframe();
        test_spurious_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
`default_nettype wire
